// File: rtl/aes_pkg.sv
// Shared AES byte-level types and index helpers for the round datapath stages.
package aes_pkg;
  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SUB,
    ST_EMIT
  } sbsr_state_t;

  // Output byte k of ShiftRows reads row k%4 from column (k/4 + k%4) % 4.
  function automatic logic [3:0] shiftrows_idx(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    r = k[1:0];
    c = k[3:2] + k[1:0];
    return {c, r};
  endfunction
endpackage

// File: rtl/subbytes_shiftrows_seq_if.sv
// Byte streams in/out of the SubBytes+ShiftRows stage plus the S-box port pair.
interface subbytes_shiftrows_seq_if;
  import aes_pkg::*;

  logic      in_valid;
  logic      in_ready;
  aes_byte_t in_data;
  aes_byte_t sbox_in;
  aes_byte_t sbox_out;
  logic      out_valid;
  logic      out_ready;
  aes_byte_t out_data;
  logic      busy;

  modport slave (
    input  in_valid, in_data, sbox_out, out_ready,
    output in_ready, sbox_in, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, sbox_out, out_ready,
    input  in_ready, sbox_in, out_valid, out_data, busy
  );
endinterface

// File: rtl/subbytes_shiftrows_seq_sbox_wb_pipe.sv
// Delays the S-box write index/enable so the writeback lines up with sbox_out.
module sbox_wb_pipe #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_en,
  input  logic [3:0] in_idx,
  output logic       out_en,
  output logic [3:0] out_idx
);
  generate
    if (LATENCY == 0) begin : g_thru
      assign out_en  = in_en;
      assign out_idx = in_idx;
    end else begin : g_pipe
      logic [LATENCY-1:0]      vld_pipe;
      logic [LATENCY-1:0][3:0] idx_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          idx_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_en;
          idx_pipe[0] <= in_idx;
          for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
          end
        end
      end

      assign out_en  = vld_pipe[LATENCY-1];
      assign out_idx = idx_pipe[LATENCY-1];
    end
  endgenerate
endmodule

// File: rtl/subbytes_shiftrows_seq.sv
// Byte-serial AES SubBytes + ShiftRows: load one state, substitute it in place
// through the shared external S-box, then stream it out in ShiftRows order.
module subbytes_shiftrows_seq
  import aes_pkg::*;
#(
  parameter int SBOX_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  subbytes_shiftrows_seq_if.slave bus
);
  localparam logic [4:0] SUB_LAST = 5'(15 + SBOX_LATENCY);

  sbsr_state_t state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [4:0]  issue, issue_nx;
  aes_byte_t   state_buf [AES_BLOCK_BYTES];
  logic        load_we;
  logic        issue_en;
  logic        wb_en;
  logic [3:0]  wb_idx;

  sbox_wb_pipe #(.LATENCY(SBOX_LATENCY)) u_wb_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_en   (issue_en),
    .in_idx  (issue[3:0]),
    .out_en  (wb_en),
    .out_idx (wb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      idx   <= '0;
      issue <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      issue <= issue_nx;
    end
  end

  // Load and writeback never coincide: writebacks drain before SUB ends.
  always_ff @(posedge clk) begin
    if (load_we) state_buf[idx] <= bus.in_data;
    if (wb_en)   state_buf[wb_idx] <= bus.sbox_out;
  end

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    issue_nx      = issue;
    load_we       = 1'b0;
    issue_en      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.sbox_in   = '0;
    bus.out_data  = '0;
    unique case (state)
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          load_we = 1'b1;
          idx_nx  = 4'(idx + 4'd1);
          if (idx == 4'd15) state_nx = ST_SUB;
        end
      end
      ST_SUB: begin
        // Issue bytes 0..15, then idle while the last results write back.
        issue_en = ~issue[4];
        if (issue_en) bus.sbox_in = state_buf[issue[3:0]];
        if (issue == SUB_LAST) begin
          state_nx = ST_EMIT;
          issue_nx = '0;
          idx_nx   = '0;
        end else begin
          issue_nx = 5'(issue + 5'd1);
        end
      end
      ST_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = state_buf[shiftrows_idx(idx)];
        if (bus.out_ready) begin
          idx_nx = 4'(idx + 4'd1);
          if (idx == 4'd15) state_nx = ST_LOAD;
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end
endmodule

// File: tb/tb_subbytes_shiftrows_seq.sv
// Directed bench: three DUT copies (S-box latency 0, 1, 3) each fed by a LUT S-box.
module tb_subbytes_shiftrows_seq;
  typedef logic [7:0] blk_t [16];

  localparam int BUDGET = 400;

  logic       clk;
  logic       rst_n;
  logic       iv    [3];
  logic [7:0] idata [3];
  logic       ordy  [3];
  logic       ir    [3];
  logic       ov    [3];
  logic [7:0] od    [3];
  logic       bsy   [3];
  logic [7:0] sin   [3];
  logic [7:0] sbox_lut [256];
  int         acc_edge [3];
  int         cyc;
  int         checks;
  int         errors;

  blk_t fips_in  = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                     8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
  blk_t fips_exp = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                     8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
  blk_t inc_in   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                     8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f};
  blk_t inc_exp  = '{8'h63, 8'h6b, 8'h67, 8'h76, 8'hf2, 8'h01, 8'hab, 8'h7b,
                     8'h30, 8'hd7, 8'h77, 8'hc5, 8'hfe, 8'h7c, 8'h6f, 8'h2b};
  blk_t zero_in  = '{default: 8'h00};
  blk_t zero_exp = '{default: 8'h63};
  blk_t ones_in  = '{default: 8'h11};
  blk_t ones_exp = '{default: 8'h82};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 2) ? 3 : g;
      logic [7:0] sb_q [4];

      subbytes_shiftrows_seq_if bus ();

      subbytes_shiftrows_seq #(.SBOX_LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );

      assign bus.in_valid  = iv[g];
      assign bus.in_data   = idata[g];
      assign bus.out_ready = ordy[g];
      assign ir[g]  = bus.in_ready;
      assign ov[g]  = bus.out_valid;
      assign od[g]  = bus.out_data;
      assign bsy[g] = bus.busy;
      assign sin[g] = bus.sbox_in;

      always @(posedge clk) begin
        sb_q[0] <= sbox_lut[bus.sbox_in];
        for (int s = 1; s < 4; s++) sb_q[s] <= sb_q[s-1];
      end
      assign bus.sbox_out = (L == 0) ? sbox_lut[bus.sbox_in] : sb_q[(L == 0) ? 0 : L - 1];
    end
  endgenerate

  function automatic int lat_of(input int d);
    return (d == 2) ? 3 : d;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h00;
    for (int y = 1; y < 256; y++)
      if (a != 8'h00 && gmul(a, 8'(y)) == 8'h01) b = 8'(y);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_in_ready"},  32'(ir[d]),  1);
    chk({tag, "_out_valid"}, 32'(ov[d]),  0);
    chk({tag, "_busy"},      32'(bsy[d]), 0);
    chk({tag, "_sbox_in"},   32'(sin[d]), 0);
    chk({tag, "_out_data"},  32'(od[d]),  0);
  endtask

  // Drive one block; the accept happens on the posedge after each negedge here.
  task automatic load_block(input int d, input blk_t blk, input bit gaps);
    int i, n;
    i = 0; n = 0;
    while (i < 16 && n < BUDGET) begin
      if (gaps && $urandom_range(0, 2) == 0) iv[d] = 1'b0;
      else begin
        iv[d]    = 1'b1;
        idata[d] = blk[i];
      end
      chk("out_valid_low_in_load", 32'(ov[d]), 0);
      if (iv[d] && ir[d]) begin
        if (i == 15) acc_edge[d] = cyc + 1;
        i++;
      end
      @(negedge clk);
      n++;
    end
    iv[d] = 1'b0;
    chk("load_done", 32'(i), 16);
  endtask

  task automatic drain_block(input int d, input blk_t exp, input int nx, input bit stall);
    int k, n;
    logic prev_ov, prev_stall;
    logic [7:0] prev_d;
    k = 0; n = 0; prev_ov = 1'b0; prev_stall = 1'b0; prev_d = 8'h00;
    while (k < nx && n < BUDGET) begin
      ordy[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("ready_valid_exclusive", 32'(ir[d] & ov[d]), 0);
      chk("busy_blocks_input", 32'(bsy[d] & ir[d]), 0);
      if (!ov[d]) chk("out_data_zero_idle", 32'(od[d]), 0);
      else        chk("sbox_in_zero_emit", 32'(sin[d]), 0);
      if (ov[d] && !prev_ov)
        chk("first_valid_latency", 32'(cyc - acc_edge[d]), 32'(16 + lat_of(d)));
      if (prev_stall) begin
        chk("out_valid_held", 32'(ov[d]), 1);
        chk("out_data_stable", 32'(od[d]), 32'(prev_d));
      end
      if (ov[d] && ordy[d]) begin
        chk($sformatf("data_d%0d_k%0d", d, k), 32'(od[d]), 32'(exp[k]));
        k++;
      end
      prev_stall = ov[d] && !ordy[d];
      prev_d     = od[d];
      prev_ov    = ov[d];
      @(negedge clk);
      n++;
    end
    ordy[d] = 1'b0;
    chk("drain_done", 32'(k), 32'(nx));
    if (nx == 16) chk("ready_after_emit", 32'(ir[d]), 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; idata[d] = 8'h00; ordy[d] = 1'b0; acc_edge[d] = 0;
    end
    for (int x = 0; x < 256; x++) sbox_lut[x] = sbox_f(8'(x));

    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_idle(d, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 round 1, then all-zero, then 00..0f with gaps and stalls.
    load_block(1, fips_in, 1'b0);
    drain_block(1, fips_exp, 16, 1'b0);
    load_block(1, zero_in, 1'b0);
    drain_block(1, zero_exp, 16, 1'b0);
    load_block(1, inc_in, 1'b1);
    drain_block(1, inc_exp, 16, 1'b1);

    // Abort in SUB cycle 5.
    load_block(1, fips_in, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle(1, "abort_sub");
    @(negedge clk);
    rst_n = 1'b1;
    load_block(1, ones_in, 1'b0);
    drain_block(1, ones_exp, 16, 1'b0);

    // Abort in EMIT after three transfers.
    load_block(1, fips_in, 1'b0);
    drain_block(1, fips_exp, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle(1, "abort_emit");
    @(negedge clk);
    rst_n = 1'b1;
    load_block(1, ones_in, 1'b0);
    drain_block(1, ones_exp, 16, 1'b0);

    // Latency sweep on the 0- and 3-cycle copies.
    load_block(0, fips_in, 1'b0);
    drain_block(0, fips_exp, 16, 1'b0);
    load_block(2, fips_in, 1'b0);
    drain_block(2, fips_exp, 16, 1'b1);

    // Back-to-back blocks with in_valid never dropping.
    load_block(1, fips_in, 1'b0);
    iv[1] = 1'b1; idata[1] = inc_in[0];
    drain_block(1, fips_exp, 16, 1'b0);
    load_block(1, inc_in, 1'b0);
    iv[1] = 1'b1; idata[1] = ones_in[0];
    drain_block(1, inc_exp, 16, 1'b0);
    load_block(1, ones_in, 1'b0);
    drain_block(1, ones_exp, 16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
